instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage directly downstream of the unified memory block.
- Owns the program counter and sequences the memory's two-phase instruction read: i_read/i_addr in one cycle, then i_push the next, with capture from d_bus.
- Holds the fetched word and its PC for decode under a valid/ready handshake.
- Yields the memory port to the data stage and redirects on jumps.

Parameters:
- RESET_PC, 16'h0010, PC loaded on reset (first code word).
- PC_STEP, 16'h0001, PC increment per fetched word.

Ports:
- clk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous, active-high reset
- d_bus  input  16  shared memory data bus; fetch only samples it
- d_req  input  1  data stage wants the memory port this cycle; has priority over a new fetch
- i_addr  output  16  instruction address to memory
- i_read  output  1  instruction read strobe to memory
- i_push  output  1  memory drives latched word onto d_bus
- fetch_lock  output  1  high in PUSH; data stage must not assert d_read/d_write/d_push
- instr  output  16  fetched instruction word
- instr_pc  output  16  address instr was fetched from
- instr_valid  output  1  instr/instr_pc valid for decode
- instr_ready  input  1  decode accepts instr this cycle
- jump_valid  input  1  redirect request, one-cycle pulse
- jump_target  input  16  new PC when jump_valid

Behaviour:
- Reset (async, immediate):
  - pc=RESET_PC, state=READ.
  - instr=0, instr_pc=0, instr_valid=0.
  - i_read=0, i_push=0, fetch_lock=0.
  - i_addr=pc.
- States:
  - READ: i_addr=pc; i_read = !d_req.
    - d_req=1: stay in READ (stall).
    - Otherwise go to PUSH.
  - PUSH: i_push=1, fetch_lock=1, i_read=0, d_req ignored.
    - Capture instr<=d_bus, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP.
    - Go to HOLD.
  - HOLD: no memory strobes.
    - Go to READ on the edge where instr_valid && instr_ready; instr_valid<=0 on that edge.
- Latency: 2 cycles from READ (with d_req=0) to instr_valid=1. Max throughput 1 word per 3 cycles without the optional feature.
- Handshake:
  - instr and instr_pc stay stable while instr_valid=1 && !instr_ready.
  - instr_ready while instr_valid=0 has no effect.
- PC arithmetic: 16-bit modulo; 16'hFFFF+1 wraps to 16'h0000.
- Jump (highest priority, any state):
  - On an edge with jump_valid=1: pc<=jump_target, instr_valid<=0, state<=READ.
  - Any word being captured in PUSH that edge is discarded.
  - jump_valid in the same cycle as instr_ready still counts as consumption of the current instr, then flushes.
  - jump_valid and d_req together: jump taken; next READ stalls on d_req as normal.
- Bus rule: i_read and i_push are never high in the same cycle. i_read is never high while d_req=1.
- Reset mid-PUSH: capture is abandoned; outputs return to reset values immediately.

Optional Feature:
- PREFETCH_EN: adds a one-entry prefetch buffer (pbuf, pbuf_pc, pbuf_valid).
- With PREFETCH_EN:
  - After PUSH, the FSM returns to READ instead of HOLD when instr is not yet accepted or the buffer is empty.
  - The next word fills pbuf when instr_valid=1 and instr_ready=0.
  - On acceptance, pbuf moves to instr the same edge.
  - Fetching stops only when both instr and pbuf are full.
  - Sustained throughput is 1 word per 2 cycles with instr_ready tied high.
  - jump_valid flushes both entries.
- Without it: behaviour is exactly the three-state FSM above.

Test Plan:
- Reset, d_req=0, instr_ready=1, memory words [16]=16'hA000, [17]=16'hB014: i_addr=16, i_push next cycle, instr=16'hA000 with instr_pc=16 and instr_valid at cycle 2; then 16'hB014 with instr_pc=17.
- Hold d_req=1 for 4 cycles in READ: i_read stays 0 and pc stays unchanged; fetch resumes the cycle after d_req falls. In PUSH, d_req=1 is ignored and fetch_lock=1.
- instr_ready=0 for 5 cycles after instr_valid: instr and instr_pc stable, no i_read/i_push (no PREFETCH_EN); next fetch starts after ready.
- jump_valid with jump_target=16'h0002 during PUSH: captured word discarded, instr_valid=0, next i_addr=2, instr_pc of next instr=2.
- pc=16'hFFFF fetch: next i_addr=16'h0000. Async rst asserted mid-PUSH: outputs reset immediately, next i_addr=16'h0010.
- PREFETCH_EN, instr_ready low 6 cycles then high: exactly two words buffered, delivered in order on consecutive ready edges; i_read/i_push alternate every cycle with ready high.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage that sits directly behind the unified memory block.
// It owns the program counter and runs the memory's two-phase read: an
// address/strobe cycle (i_read, i_addr) followed by a push cycle (i_push) in
// which the memory drives the latched word onto d_bus and this block captures
// it. The fetched word and its address are held for decode under a
// valid/ready handshake. The data stage (d_req) takes priority over starting
// a new fetch, and jump_valid redirects the PC from any state.
//
// Optional build macro:
//   PREFETCH_EN - adds a one-entry prefetch buffer behind instr, so the next
//                 word can be fetched while decode still holds the current
//                 one (1 word per 2 cycles with instr_ready tied high).
//
// Handshake: a word transfers to decode on every rising clk edge where
// instr_valid && instr_ready. While instr_valid=1 and instr_ready=0, instr
// and instr_pc hold their values. instr_ready while instr_valid=0 is ignored.
//
// Ports:
//   clk          in   1   system clock, all state on posedge
//   rst          in   1   asynchronous, active-high reset
//   d_bus        in  16   shared memory data bus (sampled in PUSH only)
//   d_req        in   1   data stage wants the memory port this cycle
//   i_addr       out 16   instruction address to memory (= pc)
//   i_read       out  1   instruction read strobe (READ state, d_req low)
//   i_push       out  1   memory drives latched word onto d_bus
//   fetch_lock   out  1   high in PUSH; data stage must stay off the bus
//   instr        out 16   fetched instruction word
//   instr_pc     out 16   address instr was fetched from
//   instr_valid  out  1   instr/instr_pc valid for decode
//   instr_ready  in   1   decode accepts instr this cycle
//   jump_valid   in   1   redirect request (one-cycle pulse)
//   jump_target  in  16   new PC when jump_valid
//   dbg_state    out  2   current FSM state (READ=0, PUSH=1, HOLD=2)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0010,
  parameter logic [15:0] PC_STEP  = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_bus,
  input  logic        d_req,
  output logic [15:0] i_addr,
  output logic        i_read,
  output logic        i_push,
  output logic        fetch_lock,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump_valid,
  input  logic [15:0] jump_target,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_READ = 2'd0,
    ST_PUSH = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_instr;
  logic [15:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_push;

`ifdef PREFETCH_EN
  logic [15:0] r_pbuf;
  logic [15:0] r_pbuf_pc;
  logic        r_pbuf_valid;
`endif

  // Decode takes the current word on this edge.
  logic w_consume;
  assign w_consume = r_instr_valid && instr_ready;

  // i_read follows d_req combinationally so the data stage can claim the
  // port in the same cycle. It is also forced low while rst is held so the
  // memory never sees a strobe during reset.
  assign i_addr      = r_pc;
  assign i_read      = (r_state == ST_READ) && !d_req && !rst;
  assign i_push      = r_push;
  assign fetch_lock  = r_push;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign dbg_state   = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_READ;
      r_pc          <= RESET_PC;
      r_instr       <= 16'h0000;
      r_instr_pc    <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_push        <= 1'b0;
`ifdef PREFETCH_EN
      r_pbuf        <= 16'h0000;
      r_pbuf_pc     <= 16'h0000;
      r_pbuf_valid  <= 1'b0;
`endif
    end else begin
      // r_push is high exactly in the cycles the FSM sits in PUSH.
      r_push <= 1'b0;

      if (jump_valid) begin
        // Redirect wins over everything: any word being captured this edge
        // and any held words are dropped. A simultaneous instr_ready still
        // counts as consumption of the current word, which needs no extra
        // action since the word is flushed either way.
        r_pc          <= jump_target;
        r_instr_valid <= 1'b0;
`ifdef PREFETCH_EN
        r_pbuf_valid  <= 1'b0;
`endif
        r_state       <= ST_READ;
      end else begin
        case (r_state)
          ST_READ: begin
`ifdef PREFETCH_EN
            // With prefetch, decode may still hold a word while we fetch.
            if (w_consume) begin
              if (r_pbuf_valid) begin
                r_instr      <= r_pbuf;
                r_instr_pc   <= r_pbuf_pc;
                r_pbuf_valid <= 1'b0;
              end else begin
                r_instr_valid <= 1'b0;
              end
            end
`endif
            // Data stage has priority; stall here until it lets go.
            if (!d_req) begin
              r_state <= ST_PUSH;
              r_push  <= 1'b1;
            end
          end

          ST_PUSH: begin
            // d_req is ignored here: fetch_lock keeps the data stage off.
            r_pc <= r_pc + PC_STEP;
`ifdef PREFETCH_EN
            // pbuf is always empty in PUSH: fetching only starts when at
            // least one slot is free, and instr is filled before pbuf.
            if (!r_instr_valid || instr_ready) begin
              r_instr       <= d_bus;
              r_instr_pc    <= r_pc;
              r_instr_valid <= 1'b1;
              r_state       <= ST_READ;
            end else begin
              r_pbuf        <= d_bus;
              r_pbuf_pc     <= r_pc;
              r_pbuf_valid  <= 1'b1;
              r_state       <= ST_HOLD;
            end
`else
            r_instr       <= d_bus;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_state       <= ST_HOLD;
`endif
          end

          ST_HOLD: begin
            // Nothing to fetch into; wait for decode to free a slot.
            if (w_consume) begin
`ifdef PREFETCH_EN
              if (r_pbuf_valid) begin
                r_instr      <= r_pbuf;
                r_instr_pc   <= r_pbuf_pc;
                r_pbuf_valid <= 1'b0;
              end else begin
                r_instr_valid <= 1'b0;
              end
`else
              r_instr_valid <= 1'b0;
`endif
              r_state <= ST_READ;
            end
          end

          default: begin
            r_state <= ST_READ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A small memory model latches i_addr on
// i_read and drives the word onto d_bus during i_push. A cycle table of
// {inputs, expected outputs} is applied one entry per clock; every word
// decode accepts is compared against an expected queue. Hand-written
// sequences cover reset values and an asynchronous reset in the middle of
// PUSH. Build with +define+PREFETCH_EN to exercise the prefetch variant.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] d_bus;
  logic        d_req;
  logic [15:0] i_addr;
  logic        i_read;
  logic        i_push;
  logic        fetch_lock;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        d_req;
    logic        rdy;
    logic        jv;
    logic [15:0] jt;
    logic        e_read;
    logic        e_push;
    logic        e_lock;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_instr;
    logic [15:0] e_pc;
  } vec_t;

  vec_t vecs[32];
  int   n_vec;

  instr_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .d_bus       (d_bus),
    .d_req       (d_req),
    .i_addr      (i_addr),
    .i_read      (i_read),
    .i_push      (i_push),
    .fetch_lock  (fetch_lock),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0010) return 16'hA000;
    if (a == 16'h0011) return 16'hB014;
    return a ^ 16'h5A00;
  endfunction

  logic [15:0] lat_addr = 16'h0000;
  always @(posedge clk) if (i_read) lat_addr <= i_addr;
  assign d_bus = i_push ? mem_word(lat_addr) : 16'hEEEE;

  // ---------------- helpers ----------------
  function automatic vec_t mk(input logic dq, input logic rdy, input logic jv,
                              input logic [15:0] jt, input logic er, input logic ep,
                              input logic el, input logic [15:0] ea, input logic ev,
                              input logic [15:0] ei, input logic [15:0] epc);
    vec_t v;
    v.d_req = dq; v.rdy = rdy; v.jv = jv; v.jt = jt;
    v.e_read = er; v.e_push = ep; v.e_lock = el; v.e_addr = ea;
    v.e_valid = ev; v.e_instr = ei; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_vec(input vec_t v);
    d_req       = v.d_req;
    instr_ready = v.rdy;
    jump_valid  = v.jv;
    jump_target = v.jt;
  endtask

  // Compare outputs for one table entry and score any accepted word.
  task automatic check_vec(input vec_t v, input int idx);
    logic [31:0] w;
    chk($sformatf("v%0d_i_read", idx), {31'd0, i_read}, {31'd0, v.e_read});
    chk($sformatf("v%0d_i_push", idx), {31'd0, i_push}, {31'd0, v.e_push});
    chk($sformatf("v%0d_lock", idx), {31'd0, fetch_lock}, {31'd0, v.e_lock});
    chk($sformatf("v%0d_i_addr", idx), {16'd0, i_addr}, {16'd0, v.e_addr});
    chk($sformatf("v%0d_valid", idx), {31'd0, instr_valid}, {31'd0, v.e_valid});
    if (v.e_valid) begin
      chk($sformatf("v%0d_instr", idx), {16'd0, instr}, {16'd0, v.e_instr});
      chk($sformatf("v%0d_instr_pc", idx), {16'd0, instr_pc}, {16'd0, v.e_pc});
    end
    chk($sformatf("v%0d_bus_rule", idx),
        {31'd0, (i_read && i_push) || (i_read && d_req)}, 32'd0);
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL v%0d_accept: got %h%h expected none", idx, instr_pc, instr);
      end else begin
        w = exp_q.pop_front();
        chk($sformatf("v%0d_accept", idx), {instr_pc, instr}, w);
      end
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply_vec(input vec_t v, input int idx);
    drive_vec(v);
    #1;
    check_vec(v, idx);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_i_addr"}, {16'd0, i_addr}, 32'h0010);
    chk({tag, "_i_read"}, {31'd0, i_read}, 32'd0);
    chk({tag, "_i_push"}, {31'd0, i_push}, 32'd0);
    chk({tag, "_lock"}, {31'd0, fetch_lock}, 32'd0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, {16'd0, instr}, 32'd0);
    chk({tag, "_instr_pc"}, {16'd0, instr_pc}, 32'd0);
    chk({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    // Fields: d_req, rdy, jv, jt | i_read, i_push, lock, i_addr, valid, instr, instr_pc
`ifdef PREFETCH_EN
    vecs[0]  = mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0010, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h0010, 0, 16'h0000, 16'h0000);
    vecs[2]  = mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0011, 1, 16'hA000, 16'h0010);
    vecs[3]  = mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h0011, 1, 16'hA000, 16'h0010);
    vecs[4]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0012, 1, 16'hA000, 16'h0010);
    vecs[5]  = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0012, 1, 16'hA000, 16'h0010);
    vecs[6]  = mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0012, 1, 16'hA000, 16'h0010);
    vecs[7]  = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0012, 1, 16'hB014, 16'h0011);
    vecs[8]  = mk(0, 1, 0, 16'h0000, 0, 1, 1, 16'h0012, 0, 16'h0000, 16'h0000);
    vecs[9]  = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0013, 1, 16'h5A12, 16'h0012);
    vecs[10] = mk(0, 1, 0, 16'h0000, 0, 1, 1, 16'h0013, 0, 16'h0000, 16'h0000);
    vecs[11] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0014, 1, 16'h5A13, 16'h0013);
    vecs[12] = mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h0014, 1, 16'h5A13, 16'h0013);
    vecs[13] = mk(0, 0, 1, 16'h0002, 0, 0, 0, 16'h0015, 1, 16'h5A13, 16'h0013);
    vecs[14] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0002, 0, 16'h0000, 16'h0000);
    vecs[15] = mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000);
    n_vec = 16;
    exp_q.push_back({16'h0010, 16'hA000});
    exp_q.push_back({16'h0011, 16'hB014});
    exp_q.push_back({16'h0012, 16'h5A12});
`else
    vecs[0]  = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0010, 0, 16'h0000, 16'h0000);
    vecs[1]  = mk(0, 1, 0, 16'h0000, 0, 1, 1, 16'h0010, 0, 16'h0000, 16'h0000);
    vecs[2]  = mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0011, 1, 16'hA000, 16'h0010);
    vecs[3]  = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0011, 0, 16'h0000, 16'h0000);
    vecs[4]  = mk(0, 1, 0, 16'h0000, 0, 1, 1, 16'h0011, 0, 16'h0000, 16'h0000);
    for (int i = 5; i <= 9; i++)
      vecs[i] = mk(0, 0, 0, 16'h0000, 0, 0, 0, 16'h0012, 1, 16'hB014, 16'h0011);
    vecs[10] = mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0012, 1, 16'hB014, 16'h0011);
    for (int i = 11; i <= 14; i++)
      vecs[i] = mk(1, 1, 0, 16'h0000, 0, 0, 0, 16'h0012, 0, 16'h0000, 16'h0000);
    vecs[15] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0012, 0, 16'h0000, 16'h0000);
    vecs[16] = mk(1, 1, 0, 16'h0000, 0, 1, 1, 16'h0012, 0, 16'h0000, 16'h0000);
    vecs[17] = mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0013, 1, 16'h5A12, 16'h0012);
    vecs[18] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0013, 0, 16'h0000, 16'h0000);
    vecs[19] = mk(0, 1, 1, 16'h0002, 0, 1, 1, 16'h0013, 0, 16'h0000, 16'h0000);
    vecs[20] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0002, 0, 16'h0000, 16'h0000);
    vecs[21] = mk(0, 1, 0, 16'h0000, 0, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000);
    vecs[22] = mk(0, 1, 1, 16'hFFFF, 0, 0, 0, 16'h0003, 1, 16'h5A02, 16'h0002);
    vecs[23] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'hFFFF, 0, 16'h0000, 16'h0000);
    vecs[24] = mk(0, 1, 0, 16'h0000, 0, 1, 1, 16'hFFFF, 0, 16'h0000, 16'h0000);
    vecs[25] = mk(0, 1, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'hA5FF, 16'hFFFF);
    vecs[26] = mk(1, 1, 1, 16'h0030, 0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    vecs[27] = mk(1, 1, 0, 16'h0000, 0, 0, 0, 16'h0030, 0, 16'h0000, 16'h0000);
    vecs[28] = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0030, 0, 16'h0000, 16'h0000);
    vecs[29] = mk(0, 1, 0, 16'h0000, 0, 1, 1, 16'h0030, 0, 16'h0000, 16'h0000);
    n_vec = 30;
    exp_q.push_back({16'h0010, 16'hA000});
    exp_q.push_back({16'h0011, 16'hB014});
    exp_q.push_back({16'h0012, 16'h5A12});
    exp_q.push_back({16'h0002, 16'h5A02});
    exp_q.push_back({16'hFFFF, 16'hA5FF});
`endif

    // Reset block: hold reset for two cycles, check reset outputs.
    rst = 1'b1;
    d_req = 1'b0;
    instr_ready = 1'b0;
    jump_valid = 1'b0;
    jump_target = 16'h0000;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Main table; the last entry is left in PUSH for the async reset test.
    for (int i = 0; i < n_vec - 1; i++) apply_vec(vecs[i], i);
    drive_vec(vecs[n_vec - 1]);
    #1;
    check_vec(vecs[n_vec - 1], n_vec - 1);

    // Asynchronous reset in the middle of PUSH, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid_push");
    @(negedge clk);
    rst = 1'b0;

    // Fetch restarts from RESET_PC.
`ifndef PREFETCH_EN
    exp_q.push_back({16'h0010, 16'hA000});
`endif
    apply_vec(vecs[0], 100);
    apply_vec(vecs[1], 101);
    apply_vec(vecs[2], 102);

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
